page_rank: RTL and testbench

Memory-mapped PageRank accumulation stage: a host configures it through a 64-bit soft-register port, and it fetches graph parameters and per-vertex values over a 512-bit AXI master. It computes the inclusive prefix sum of the vertex values, optionally writes those sums back to memory, and reports the 64-bit total to the host. It sits between the host soft-register shell and the AXI memory (`axi_emu` in simulation).

---
 rtl/page_rank.sv | 278 +++++++++++++++++++++++++++
 tb/tb_page_rank.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_rank.sv
`default_nettype none
// ============================================================================
// Module   : page_rank
// Brief    : PageRank accumulation stage. Fetches vertex values over a 512-bit
//            AXI master, forms their running prefix sum and reports the 64-bit
//            total over the soft-register port. Define PR_WRITEBACK_EN to
//            write each prefix line back to memory.
// Revision : 1.0 - initial release
// ============================================================================
module page_rank (
    input  logic          clk,
    input  logic          rst,

    output logic [15:0]   arid_m,
    output logic [63:0]   araddr_m,
    output logic [7:0]    arlen_m,
    output logic [2:0]    arsize_m,
    output logic          arvalid_m,
    input  logic          arready_m,

    input  logic [15:0]   rid_m,
    input  logic [511:0]  rdata_m,
    input  logic [1:0]    rresp_m,
    input  logic          rlast_m,
    input  logic          rvalid_m,
    output logic          rready_m,

    output logic [15:0]   awid_m,
    output logic [63:0]   awaddr_m,
    output logic [7:0]    awlen_m,
    output logic [2:0]    awsize_m,
    output logic          awvalid_m,
    input  logic          awready_m,

    output logic [15:0]   wid_m,
    output logic [511:0]  wdata_m,
    output logic [63:0]   wstrb_m,
    output logic          wlast_m,
    output logic          wvalid_m,
    input  logic          wready_m,

    input  logic [15:0]   bid_m,
    input  logic [1:0]    bresp_m,
    input  logic          bvalid_m,
    output logic          bready_m,

    input  logic          softreg_req_valid,
    input  logic          softreg_req_isWrite,
    input  logic [31:0]   softreg_req_addr,
    input  logic [63:0]   softreg_req_data,
    output logic          softreg_resp_valid,
    output logic [63:0]   softreg_resp_data
);

    localparam logic [31:0] c_ADDR_PARAMS = 32'h00;
    localparam logic [31:0] c_ADDR_VMAP   = 32'h08;
    localparam logic [31:0] c_ADDR_INFO   = 32'h10;
    localparam logic [31:0] c_ADDR_DONE   = 32'h18;
    localparam logic [31:0] c_ADDR_ITERS  = 32'h28;
    localparam logic [31:0] c_ADDR_WADDR  = 32'h30;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        P_AR  = 4'd1,
        P_R   = 4'd2,
        READY = 4'd3,
        V_AR  = 4'd4,
        V_R   = 4'd5,
        W_AW  = 4'd6,
        W_W   = 4'd7,
        W_B   = 4'd8,
        DONE  = 4'd9
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [63:0]    r_vmap_line;
    logic [63:0]    r_iters;
    logic [63:0]    r_waddr;
    logic [31:0]    r_num_v;
    logic [31:0]    r_num_e;
    logic [31:0]    r_remain;
    logic [63:0]    r_araddr;
    logic [63:0]    r_awaddr;
    logic [511:0]   r_wline;
    logic [63:0]    r_acc;
    logic           r_done;
    logic           r_pending;
    logic           r_resp_valid;
    logic [63:0]    r_resp_data;

    logic           w_req_wr;
    logic           w_req_rd;
    logic           w_can_cfg;
    logic           w_params_wr;
    logic           w_info_wr;
    logic [31:0]    w_n;
    logic           w_last;
    logic [63:0]    w_run;
    logic [511:0]   w_line;

    assign w_req_wr    = softreg_req_valid &&  softreg_req_isWrite;
    assign w_req_rd    = softreg_req_valid && !softreg_req_isWrite;
    assign w_can_cfg   = (r_state == IDLE) || (r_state == READY) || (r_state == DONE);
    assign w_params_wr = w_req_wr && (softreg_req_addr == c_ADDR_PARAMS) && w_can_cfg;
    assign w_info_wr   = w_req_wr && (softreg_req_addr == c_ADDR_INFO) &&
                         ((r_state == READY) || (r_state == DONE));
    assign w_n         = (r_iters < {32'd0, r_num_v}) ? r_iters[31:0] : r_num_v;
    assign w_last      = (r_remain <= 32'd16);

    // Words past the remaining count add nothing and repeat the running sum.
    always_comb begin
        w_run  = r_acc;
        w_line = '0;
        for (int k = 0; k < 16; k++) begin
            if (32'(k) < r_remain) begin
                w_run = w_run + {32'd0, rdata_m[32*k +: 32]};
            end
            w_line[32*k +: 32] = w_run[31:0];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, READY, DONE: begin
                if (w_params_wr) begin
                    w_next = P_AR;
                end else if (w_info_wr) begin
                    w_next = (w_n == 32'd0) ? DONE : V_AR;
                end
            end
            P_AR:    if (arready_m) w_next = P_R;
            P_R:     if (rvalid_m)  w_next = READY;
            V_AR:    if (arready_m) w_next = V_R;
            V_R: begin
                if (rvalid_m) begin
`ifdef PR_WRITEBACK_EN
                    w_next = W_AW;
`else
                    w_next = w_last ? DONE : V_AR;
`endif
                end
            end
            W_AW:    if (awready_m) w_next = W_W;
            W_W:     if (wready_m)  w_next = W_B;
            W_B:     if (bvalid_m)  w_next = (r_remain == 32'd0) ? DONE : V_AR;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vmap_line  <= '0;
            r_iters      <= '0;
            r_waddr      <= '0;
            r_num_v      <= '0;
            r_num_e      <= '0;
            r_remain     <= '0;
            r_araddr     <= '0;
            r_awaddr     <= '0;
            r_wline      <= '0;
            r_acc        <= '0;
            r_done       <= 1'b0;
            r_pending    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= 1'b0;

            if (w_req_wr) begin
                case (softreg_req_addr)
                    c_ADDR_VMAP:  r_vmap_line <= softreg_req_data;
                    c_ADDR_ITERS: r_iters     <= softreg_req_data;
                    c_ADDR_WADDR: r_waddr     <= softreg_req_data;
                    default: ;
                endcase
            end

            if (w_params_wr) begin
                r_araddr <= softreg_req_data << 6;
            end

            if (w_info_wr) begin
                r_araddr <= softreg_req_data << 6;
                r_awaddr <= r_waddr;
                r_remain <= w_n;
                r_acc    <= '0;
                r_done   <= (w_n == 32'd0);
            end

            if (r_state == P_R && rvalid_m) begin
                r_num_v <= rdata_m[31:0];
                r_num_e <= rdata_m[63:32];
            end

            if (r_state == V_R && rvalid_m) begin
                r_acc    <= w_run;
                r_wline  <= w_line;
                r_remain <= w_last ? 32'd0 : (r_remain - 32'd16);
                r_araddr <= r_araddr + 64'd64;
            end

            if (r_state == W_B && bvalid_m) begin
                r_awaddr <= r_awaddr + 64'd64;
            end

            if (r_state != DONE && w_next == DONE) begin
                r_done <= 1'b1;
            end

            // A DONE read that arrived mid-pass is answered once the pass ends.
            if (r_pending && r_done) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= r_acc;
                r_pending    <= 1'b0;
            end

            if (w_req_rd) begin
                if (softreg_req_addr == c_ADDR_DONE) begin
                    if (r_done) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= r_acc;
                    end else begin
                        r_pending <= 1'b1;
                    end
                end else begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= '0;
                end
            end
        end
    end

    assign arid_m    = '0;
    assign araddr_m  = r_araddr;
    assign arlen_m   = '0;
    assign arsize_m  = 3'd6;
    assign arvalid_m = (r_state == P_AR) || (r_state == V_AR);
    assign rready_m  = (r_state == P_R)  || (r_state == V_R);

    assign awid_m    = '0;
    assign awaddr_m  = r_awaddr;
    assign awlen_m   = '0;
    assign awsize_m  = 3'd6;
    assign wid_m     = '0;
    assign wdata_m   = r_wline;
    assign wstrb_m   = '1;
    assign wlast_m   = 1'b1;

`ifdef PR_WRITEBACK_EN
    assign awvalid_m = (r_state == W_AW);
    assign wvalid_m  = (r_state == W_W);
    assign bready_m  = (r_state == W_B);
`else
    assign awvalid_m = 1'b0;
    assign wvalid_m  = 1'b0;
    assign bready_m  = 1'b1;
`endif

    assign softreg_resp_valid = r_resp_valid;
    assign softreg_resp_data  = r_resp_data;

    // Inputs and stored fields that this stage does not consume.
    logic w_unused_ok;
    assign w_unused_ok = ^{rid_m, rresp_m, rlast_m, bid_m, bresp_m, r_num_e, r_vmap_line};

endmodule
`default_nettype wire

// File: tb/tb_page_rank.sv
`default_nettype none
// ============================================================================
// Module   : tb_page_rank
// Brief    : Self-checking bench for page_rank with an AXI memory responder
//            and a soft-register response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_page_rank;

`ifdef PR_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]  arid_m;   logic [63:0] araddr_m; logic [7:0] arlen_m; logic [2:0] arsize_m;
    logic         arvalid_m, arready_m;
    logic [15:0]  rid_m;    logic [511:0] rdata_m; logic [1:0] rresp_m;
    logic         rlast_m, rvalid_m, rready_m;
    logic [15:0]  awid_m;   logic [63:0] awaddr_m; logic [7:0] awlen_m; logic [2:0] awsize_m;
    logic         awvalid_m, awready_m;
    logic [15:0]  wid_m;    logic [511:0] wdata_m; logic [63:0] wstrb_m;
    logic         wlast_m, wvalid_m, wready_m;
    logic [15:0]  bid_m;    logic [1:0] bresp_m;
    logic         bvalid_m, bready_m;
    logic         softreg_req_valid, softreg_req_isWrite;
    logic [31:0]  softreg_req_addr;
    logic [63:0]  softreg_req_data;
    logic         softreg_resp_valid;
    logic [63:0]  softreg_resp_data;

    page_rank dut (
        .clk(clk), .rst(rst),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
        .awvalid_m(awvalid_m), .awready_m(awready_m),
        .wid_m(wid_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m),
        .wvalid_m(wvalid_m), .wready_m(wready_m),
        .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
        .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
        .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
        .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data)
    );

    int errors = 0;
    int checks = 0;

    logic [511:0] mem [logic [63:0]];
    logic [63:0]  exp_q [$];

    int  ar_stall = 0, w_stall = 0;
    int  ar_count = 0, aw_count = 0, r_count = 0, resp_cnt = 0;
    bit  ar_fire, r_fire, aw_fire, w_fire, b_fire;
    bit  rd_pend, have_aw, have_w;
    int  rd_delay;
    logic [63:0]  ar_cap, aw_cap, rd_addr, aw_addr;
    logic [511:0] w_cap, w_buf;

    // Memory responder and response scoreboard; all decisions taken at negedge.
    always @(negedge clk) begin
        if (softreg_resp_valid) begin
            logic [63:0] e;
            resp_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got data %0d with no read outstanding", softreg_resp_data);
            end else begin
                e = exp_q.pop_front();
                if (softreg_resp_data !== e) begin
                    errors++;
                    $display("FAIL resp_data: got %0d expected %0d", softreg_resp_data, e);
                end
            end
        end
        if (!rst) begin
            rvalid_m = 1'b0; bvalid_m = 1'b0;
            rd_pend = 0; have_aw = 0; have_w = 0;
            ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
        end else begin
            if (r_fire) begin rvalid_m = 1'b0; r_count++; end
            if (b_fire) bvalid_m = 1'b0;
            if (ar_fire) begin rd_pend = 1; rd_addr = ar_cap; rd_delay = 2; ar_count++; end
            if (aw_fire) begin have_aw = 1; aw_addr = aw_cap; aw_count++; end
            if (w_fire)  begin have_w = 1; w_buf = w_cap; end
            if (have_aw && have_w) begin
                mem[aw_addr >> 6] = w_buf;
                have_aw = 0; have_w = 0; bvalid_m = 1'b1;
            end
            if (rd_pend) begin
                if (rd_delay == 0) begin
                    rdata_m  = mem.exists(rd_addr >> 6) ? mem[rd_addr >> 6] : '0;
                    rvalid_m = 1'b1;
                    rd_pend  = 0;
                end else begin
                    rd_delay--;
                end
            end
            arready_m = (ar_stall == 0);
            if (arvalid_m && ar_stall > 0) ar_stall--;
            wready_m = (w_stall == 0);
            if (wvalid_m && w_stall > 0) w_stall--;
            ar_fire = arvalid_m && arready_m; ar_cap = araddr_m;
            r_fire  = rvalid_m && rready_m;
            aw_fire = awvalid_m && awready_m; aw_cap = awaddr_m;
            w_fire  = wvalid_m && wready_m;   w_cap  = wdata_m;
            b_fire  = bvalid_m && bready_m;
        end
    end

    // Reference: running sum over value words 0..upto that fall below n.
    function automatic logic [63:0] model_sum(input int base, input int n, input int upto);
        logic [63:0]  s;
        logic [511:0] l;
        s = '0;
        for (int i = 0; i <= upto && i < n; i++) begin
            l = mem.exists(64'(base + i / 16)) ? mem[64'(base + i / 16)] : '0;
            s = s + {32'd0, l[32 * (i % 16) +: 32]};
        end
        return s;
    endfunction

    function automatic logic [511:0] model_line(input int base, input int n, input int j);
        logic [511:0] l;
        logic [63:0]  s;
        for (int k = 0; k < 16; k++) begin
            s = model_sum(base, n, 16 * j + k);
            l[32 * k +: 32] = s[31:0];
        end
        return l;
    endfunction

    task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
        @(negedge clk);
        softreg_req_valid = 1'b1; softreg_req_isWrite = 1'b1;
        softreg_req_addr = a; softreg_req_data = d;
        @(negedge clk);
        softreg_req_valid = 1'b0; softreg_req_isWrite = 1'b0;
    endtask

    task automatic sr_read(input logic [31:0] a, input logic [63:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        softreg_req_valid = 1'b1; softreg_req_isWrite = 1'b0; softreg_req_addr = a;
        @(negedge clk);
        softreg_req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
        ok = (exp_q.size() == 0);
        if (!ok) exp_q.delete();
    endtask

    task automatic wait_rcount(input int target, input int budget, output bit ok);
        int n = 0;
        while (r_count < target && n < budget) begin @(negedge clk); n++; end
        ok = (r_count >= target);
    endtask

    task automatic load_params(input logic [63:0] line, input string name);
        bit ok;
        int t;
        t = r_count + 1;
        sr_write(32'h00, line);
        wait_rcount(t, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s: parameter beat not consumed, r_count=%0d need %0d", name, r_count, t); end
    endtask

    task automatic test_reset();
        bit ok;
        repeat (3) @(negedge clk);
        checks++;
        if ({arvalid_m, awvalid_m, wvalid_m, rready_m, softreg_resp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b expected 00000",
                     {arvalid_m, awvalid_m, wvalid_m, rready_m, softreg_resp_valid});
        end
        checks++;
        if (bready_m !== !WB) begin errors++; $display("FAIL reset_bready: got %b expected %b", bready_m, !WB); end
        checks++;
        if ({arid_m, arlen_m, arsize_m, awid_m, awlen_m, awsize_m, wid_m, wstrb_m, wlast_m} !==
            {16'd0, 8'd0, 3'd6, 16'd0, 8'd0, 3'd6, 16'd0, {64{1'b1}}, 1'b1}) begin
            errors++;
            $display("FAIL axi_consts: got arsize=%0d awsize=%0d wstrb=%h wlast=%b", arsize_m, awsize_m, wstrb_m, wlast_m);
        end
        rst = 1'b1;
        sr_read(32'h20, 64'd0);
        wait_drain(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL other_addr_read: got no response expected immediate 0"); end
    endtask

    task automatic test_full();
        bit ok;
        int a0, w0;
        load_params(64'd0, "full_params");
        sr_write(32'h28, 64'd256);
        sr_write(32'h30, 64'h200);
        a0 = ar_count; w0 = aw_count;
        sr_write(32'h10, 64'd4);
        repeat (80) @(negedge clk);
        sr_read(32'h18, model_sum(4, 20, 19));
        wait_drain(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_total: got no response expected %0d", model_sum(4, 20, 19)); end
        checks++;
        if (ar_count - a0 !== 2) begin errors++; $display("FAIL full_reads: got %0d expected 2", ar_count - a0); end
        checks++;
        if (aw_count - w0 !== (WB ? 2 : 0)) begin errors++; $display("FAIL full_writes: got %0d expected %0d", aw_count - w0, WB ? 2 : 0); end
`ifdef PR_WRITEBACK_EN
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (mem[64'(8 + j)] !== model_line(4, 20, j)) begin
                errors++;
                $display("FAIL full_line%0d: got %h expected %h", 8 + j, mem[64'(8 + j)], model_line(4, 20, j));
            end
        end
`endif
    endtask

    task automatic test_iters_cap();
        bit ok;
        int a0, w0;
        sr_write(32'h28, 64'd5);
        a0 = ar_count; w0 = aw_count;
        sr_write(32'h10, 64'd4);
        repeat (60) @(negedge clk);
        sr_read(32'h18, model_sum(4, 5, 4));
        wait_drain(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL cap_total: got no response expected %0d", model_sum(4, 5, 4)); end
        checks++;
        if (ar_count - a0 !== 1) begin errors++; $display("FAIL cap_reads: got %0d expected 1", ar_count - a0); end
        checks++;
        if (aw_count - w0 !== (WB ? 1 : 0)) begin errors++; $display("FAIL cap_writes: got %0d expected %0d", aw_count - w0, WB ? 1 : 0); end
`ifdef PR_WRITEBACK_EN
        checks++;
        if (mem[64'd8] !== model_line(4, 5, 0)) begin errors++; $display("FAIL cap_line8: got %h expected %h", mem[64'd8], model_line(4, 5, 0)); end
        checks++;
        if (mem[64'd9] !== model_line(4, 20, 1)) begin errors++; $display("FAIL cap_line9_kept: got %h expected %h", mem[64'd9], model_line(4, 20, 1)); end
`endif
    endtask

    task automatic test_zero_vertices();
        bit ok;
        int a0;
        load_params(64'd1, "zero_params");
        sr_write(32'h28, 64'd256);
        a0 = ar_count;
        sr_write(32'h10, 64'd4);
        repeat (10) @(negedge clk);
        sr_read(32'h18, 64'd0);
        wait_drain(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL zero_total: got no response expected 0"); end
        checks++;
        if (ar_count !== a0) begin errors++; $display("FAIL zero_reads: got %0d expected 0", ar_count - a0); end
    endtask

    task automatic test_deferred();
        bit ok;
        int a0, c0;
        load_params(64'd0, "defer_params");
        a0 = ar_count; c0 = resp_cnt;
        sr_write(32'h10, 64'd4);
        sr_read(32'h18, model_sum(4, 20, 19));
        sr_write(32'h10, 64'd0);
        sr_write(32'h00, 64'd1);
        checks++;
        if (resp_cnt !== c0) begin errors++; $display("FAIL defer_early: got %0d responses expected 0 before pass end", resp_cnt - c0); end
        wait_drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL defer_resp: got no response expected %0d", model_sum(4, 20, 19)); end
        checks++;
        if (ar_count - a0 !== 2) begin errors++; $display("FAIL defer_reads: got %0d expected 2", ar_count - a0); end
        repeat (20) @(negedge clk);
        checks++;
        if (resp_cnt - c0 !== 1) begin errors++; $display("FAIL defer_pulses: got %0d expected 1", resp_cnt - c0); end
    endtask

    task automatic test_stall();
        bit ok, stable;
        int n;
        logic [63:0]  a_cap;
        ar_stall = 10;
        w_stall  = WB ? 10 : 0;
        sr_write(32'h10, 64'd4);
        n = 0;
        while (!arvalid_m && n < 10) begin @(negedge clk); n++; end
        a_cap = araddr_m;
        stable = arvalid_m;
        repeat (8) begin
            @(negedge clk);
            if (!arvalid_m || araddr_m !== a_cap) stable = 0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL stall_ar: got arvalid=%b addr=%h expected 1 addr=%h", arvalid_m, araddr_m, a_cap); end
`ifdef PR_WRITEBACK_EN
        begin
            logic [511:0] d_cap;
            n = 0;
            while (!wvalid_m && n < 100) begin @(negedge clk); n++; end
            d_cap = wdata_m;
            stable = wvalid_m;
            repeat (8) begin
                @(negedge clk);
                if (!wvalid_m || wdata_m !== d_cap) stable = 0;
            end
            checks++;
            if (!stable) begin errors++; $display("FAIL stall_w: got wvalid=%b expected stable high data", wvalid_m); end
        end
`endif
        repeat (100) @(negedge clk);
        sr_read(32'h18, model_sum(4, 20, 19));
        wait_drain(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_total: got no response expected %0d", model_sum(4, 20, 19)); end
        ar_stall = 0; w_stall = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n, w0;
        sr_write(32'h10, 64'd4);
        n = 0;
        while (!rready_m && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!rready_m) begin errors++; $display("FAIL midrst_vr: got rready=0 expected V_R reached"); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({arvalid_m, rready_m, awvalid_m, wvalid_m} !== 4'b0) begin
            errors++;
            $display("FAIL midrst_valids: got %b expected 0000", {arvalid_m, rready_m, awvalid_m, wvalid_m});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        load_params(64'd0, "midrst_params");
        sr_write(32'h28, 64'd256);
        sr_write(32'h30, 64'h200);
        w0 = aw_count;
        sr_write(32'h10, 64'd4);
        repeat (80) @(negedge clk);
        sr_read(32'h18, model_sum(4, 20, 19));
        wait_drain(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_total: got no response expected %0d", model_sum(4, 20, 19)); end
        checks++;
        if (aw_count - w0 !== (WB ? 2 : 0)) begin errors++; $display("FAIL midrst_writes: got %0d expected %0d", aw_count - w0, WB ? 2 : 0); end
    endtask

    initial begin
        logic [511:0] l;
        arready_m = 1'b1; awready_m = 1'b1; wready_m = 1'b1;
        rvalid_m = 1'b0; bvalid_m = 1'b0; rdata_m = '0; rlast_m = 1'b1;
        rid_m = '0; rresp_m = '0; bid_m = '0; bresp_m = '0;
        softreg_req_valid = 1'b0; softreg_req_isWrite = 1'b0;
        softreg_req_addr = '0; softreg_req_data = '0;

        l = '0; l[31:0] = 32'd20; l[63:32] = 32'd99; mem[64'd0] = l;
        mem[64'd1] = '0;
        l = '0; for (int k = 0; k < 16; k++) l[32 * k +: 32] = 32'(k + 1); mem[64'd4] = l;
        l = '0; for (int k = 0; k < 4; k++)  l[32 * k +: 32] = 32'(k + 17); mem[64'd5] = l;

        test_reset();
        test_full();
        test_iters_cap();
        test_zero_vertices();
        test_deferred();
        test_stall();
        test_reset_mid();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
